det_batch_ctrl: RTL and testbench

Batch sequencer for the determinant engine. It walks a list of matrices in a shared combinational-read matrix memory and resets and launches the engine once per matrix. While the engine runs, it translates the engine's (i, j) element requests into memory addresses. It returns one signed determinant per matrix on a valid/ready result port, with per-job error flags for bad dimensions and engine timeouts.

---
 rtl/det_pkg.sv | 29 ++
 rtl/det_addr_map.sv | 37 +++
 rtl/det_batch_ctrl.sv | 159 +++++++++++++++
 tb/tb_det_batch_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared definitions for the determinant batch sequencer: FSM state encoding,
// matrix-memory slot layout and the accepted matrix-dimension range.
package det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_HDR,
        ST_RUN,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Each job owns a slot of SLOT_WORDS words: header first, then the
    // elements laid out row-major with a fixed 4-word row pitch.
    localparam int unsigned SLOT_WORDS = 16;
    localparam int unsigned HDR_OFF    = 0;
    localparam int unsigned ELEM_OFF   = 4;
    localparam int unsigned ROW_STRIDE = 4;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 3;

    // True when the header dimension is one the engine can handle.
    function automatic logic n_valid(input logic [2:0] n);
        return (n >= 3'(N_MIN)) && (n <= 3'(N_MAX));
    endfunction

endpackage

// File: rtl/det_addr_map.sv
// Combinational matrix-memory address generator.
// Ports:
//   job      in  JOBS_W   current job number (selects the slot)
//   state    in  state_t  sequencer state (selects header/element/none)
//   row, col in  2        engine element request (i, j)
//   mem_addr out JOBS_W+4 word address; 0 outside HDR and RUN
module det_addr_map
    import det_pkg::*;
#(
    parameter int unsigned JOBS_W = 4
) (
    input  logic [JOBS_W-1:0] job,
    input  state_t            state,
    input  logic [1:0]        row,
    input  logic [1:0]        col,
    output logic [JOBS_W+3:0] mem_addr
);

    localparam int unsigned AW = JOBS_W + 4;

    logic [AW-1:0] base;
    logic [AW-1:0] elem;

    assign base = AW'(job) * AW'(SLOT_WORDS);
    assign elem = base + AW'(ELEM_OFF) + AW'(ROW_STRIDE) * AW'(row) + AW'(col);

    // Header read in HDR, element reads in RUN, parked at 0 otherwise.
    always_comb begin
        mem_addr = '0;
        case (state)
            ST_HDR:  mem_addr = base + AW'(HDR_OFF);
            ST_RUN:  mem_addr = elem;
            default: ;
        endcase
    end

endmodule

// File: rtl/det_batch_ctrl.sv
// Batch sequencer for the determinant engine. Walks num_jobs matrix slots,
// resets and launches the engine per job, maps engine (i, j) requests onto
// the matrix memory and returns one signed result per job on a valid/ready
// port, flagging bad dimensions and engine timeouts.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, num_jobs     batch launch pulse and job count (sampled in IDLE)
//   busy, done          not-IDLE flag, one-cycle end-of-batch pulse
//   mem_addr, mem_rdata matrix memory (combinational read)
//   eng_reset           engine reset, low only in HDR and RUN
//   eng_read_data       memory data forwarded to the engine
//   eng_i, eng_j        engine element request
//   eng_write_data      engine running result
//   eng_finish          engine completion
//   res_valid/ready     result handshake
//   res_idx, res_data   job number and signed determinant (0 on error)
//   res_err             job failed (bad n or timeout)
module det_batch_ctrl
    import det_pkg::*;
#(
    parameter int unsigned MAX     = 20,
    parameter int unsigned JOBS_W  = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [JOBS_W-1:0]   num_jobs,
    output logic                busy,
    output logic                done,
    output logic [JOBS_W+3:0]   mem_addr,
    input  logic [MAX-1:0]      mem_rdata,
    output logic                eng_reset,
    output logic [MAX-1:0]      eng_read_data,
    input  logic [MAX-1:0]      eng_i,
    input  logic [MAX-1:0]      eng_j,
    input  logic [2*MAX-1:0]    eng_write_data,
    input  logic                eng_finish,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [JOBS_W-1:0]   res_idx,
    output logic [2*MAX-1:0]    res_data,
    output logic                res_err
);

    localparam int unsigned RW    = 2 * MAX;
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    state_t             state_q;
    state_t             next_state;
    logic [JOBS_W-1:0]  job_q;
    logic [JOBS_W-1:0]  count_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               res_valid_q;
    logic               eng_reset_q;
    logic [RW-1:0]      res_data_q;
    logic               res_err_q;

    logic               n_ok;
    logic               last_job;
    logic               timed_out;
    logic               unused_req_bits;

    assign n_ok      = n_valid(mem_rdata[2:0]);
    assign last_job  = (job_q == count_q - JOBS_W'(1));
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Only the low two bits of the request index address a 4x4 slot window.
    assign unused_req_bits = ^{eng_i[MAX-1:2], eng_j[MAX-1:2]};

    det_addr_map #(
        .JOBS_W (JOBS_W)
    ) u_addr_map (
        .job      (job_q),
        .state    (state_q),
        .row      (eng_i[1:0]),
        .col      (eng_j[1:0]),
        .mem_addr (mem_addr)
    );

    assign eng_read_data = mem_rdata;

    // Next-state decode; finish is checked before timeout so it wins a tie.
    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE: if (start) next_state = (num_jobs == '0) ? ST_DONE : ST_HOLD;
            ST_HOLD: next_state = ST_HDR;
            ST_HDR:  next_state = n_ok ? ST_RUN : ST_EMIT;
            ST_RUN:  if (eng_finish || timed_out) next_state = ST_EMIT;
            ST_EMIT: if (res_ready) next_state = last_job ? ST_DONE : ST_HOLD;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State, registered outputs (decoded from next state) and job datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            eng_reset_q <= 1'b1;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            job_q       <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= next_state;
            busy_q      <= (next_state != ST_IDLE);
            done_q      <= (next_state == ST_DONE);
            res_valid_q <= (next_state == ST_EMIT);
            eng_reset_q <= !((next_state == ST_HDR) || (next_state == ST_RUN));

            case (state_q)
                ST_IDLE: begin
                    if (start && (num_jobs != '0)) begin
                        count_q <= num_jobs;
                        job_q   <= '0;
                    end
                end
                ST_HOLD: cnt_q <= '0;
                ST_HDR: begin
                    if (!n_ok) begin
                        res_err_q  <= 1'b1;
                        res_data_q <= '0;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (eng_finish) begin
                        res_data_q <= eng_write_data;
                        res_err_q  <= 1'b0;
                    end else if (timed_out) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (res_ready && !last_job) job_q <= job_q + JOBS_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign eng_reset = eng_reset_q;
    assign res_idx   = job_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_det_batch_ctrl.sv
// Self-checking bench for det_batch_ctrl: behavioural matrix memory, a
// behavioural determinant engine (optionally hanging per job) and a result
// scoreboard filled when a batch is launched.
module tb_det_batch_ctrl;

    localparam int MAX = 20;
    localparam int JW  = 4;
    localparam int TO  = 64;
    localparam int RW  = 2 * MAX;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [JW-1:0]   num_jobs;
    logic            busy;
    logic            done;
    logic [JW+3:0]   mem_addr;
    logic [MAX-1:0]  mem_rdata;
    logic            eng_reset;
    logic [MAX-1:0]  eng_read_data;
    logic [MAX-1:0]  eng_i;
    logic [MAX-1:0]  eng_j;
    logic [RW-1:0]   eng_write_data;
    logic            eng_finish;
    logic            res_valid;
    logic            res_ready;
    logic [JW-1:0]   res_idx;
    logic [RW-1:0]   res_data;
    logic            res_err;

    always #5 clk = ~clk;

    det_batch_ctrl #(.MAX(MAX), .JOBS_W(JW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_jobs       (num_jobs),
        .busy           (busy),
        .done           (done),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .eng_reset      (eng_reset),
        .eng_read_data  (eng_read_data),
        .eng_i          (eng_i),
        .eng_j          (eng_j),
        .eng_write_data (eng_write_data),
        .eng_finish     (eng_finish),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_idx        (res_idx),
        .res_data       (res_data),
        .res_err        (res_err)
    );

    // Matrix memory with combinational read.
    logic [MAX-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    // Behavioural engine: samples n on the first cycle out of reset, then
    // requests elements row-major, then presents the determinant and finish.
    logic [15:0] hang_mask = '0;
    int          e_step, e_n, e_job, ei, ej;
    longint      e_m [3][3];
    longint      det;

    always @(negedge clk) begin
        if (reset || eng_reset) begin
            e_step = 0; ei = 0; ej = 0;
            eng_finish = 1'b0;
            eng_i = '0; eng_j = '0;
        end else if (e_step == 0) begin
            e_n    = int'(eng_read_data[2:0]);
            e_job  = int'(mem_addr[7:4]);
            e_step = 1; ei = 0; ej = 0;
            eng_i = '0; eng_j = '0;
        end else if (e_step == 1 && e_n >= 2 && e_n <= 3 && !hang_mask[e_job]) begin
            e_m[ei][ej] = longint'($signed(eng_read_data));
            if (ej == e_n - 1) begin
                if (ei == e_n - 1) begin
                    if (e_n == 2)
                        det = e_m[0][0] * e_m[1][1] - e_m[0][1] * e_m[1][0];
                    else
                        det = e_m[0][0] * (e_m[1][1] * e_m[2][2] - e_m[1][2] * e_m[2][1])
                            - e_m[0][1] * (e_m[1][0] * e_m[2][2] - e_m[1][2] * e_m[2][0])
                            + e_m[0][2] * (e_m[1][0] * e_m[2][1] - e_m[1][1] * e_m[2][0]);
                    eng_write_data = RW'(det);
                    eng_finish     = 1'b1;
                    e_step         = 2;
                end else begin
                    ei = ei + 1; ej = 0;
                end
            end else begin
                ej = ej + 1;
            end
            eng_i = MAX'(ei);
            eng_j = MAX'(ej);
        end
    end

    typedef struct packed {
        logic [JW-1:0] idx;
        logic [RW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    task automatic push_exp(input int idx, input longint d, input bit err);
        exp_t e;
        e.idx  = JW'(idx);
        e.data = RW'(d);
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic load_job(input int k, input int n, input int v [9]);
        mem[k*16] = MAX'(n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                mem[k*16 + 4 + 4*i + j] = MAX'(v[i*n + j]);
    endtask

    task automatic start_batch(input int nj);
        @(negedge clk);
        start    = 1'b1;
        num_jobs = JW'(nj);
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Waits (bounded) for a handshake and returns what the DUT presented.
    task automatic wait_hs(input int budget, output logic [JW-1:0] gi,
                           output logic [RW-1:0] gd, output logic ge, output bit ok);
        ok = 1'b0; gi = '0; gd = '0; ge = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                gi = res_idx; gd = res_data; ge = res_err; ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_jobs = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%b done=%b valid=%b want 0 0 0", busy, done, res_valid);
        end
        tests++;
        if (res_err !== 1'b0 || res_data !== '0 || res_idx !== '0) begin
            fails++;
            $display("FAIL reset_res: err=%b data=%0h idx=%0d want 0 0 0", res_err, res_data, res_idx);
        end
        tests++;
        if (eng_reset !== 1'b1 || mem_addr !== '0) begin
            fails++;
            $display("FAIL reset_eng: eng_reset=%b mem_addr=%0d want 1 0", eng_reset, mem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [JW-1:0] gi; logic [RW-1:0] gd; logic ge; bit ok; exp_t e;
        load_job(0, 2, '{3, 1, 2, 4, 0, 0, 0, 0, 0});
        push_exp(0, 10, 1'b0);
        res_ready = 1'b1;
        start_batch(1);
        wait_hs(200, gi, gd, ge, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || gi !== e.idx || gd !== e.data || ge !== e.err) begin
            fails++;
            $display("FAIL single_res: ok=%b idx=%0d data=%0d err=%b want idx=%0d data=%0d err=%b",
                     ok, gi, $signed(gd), ge, e.idx, $signed(e.data), e.err);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL single_done: done=%b want 1", done);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_three_jobs();
        logic [JW-1:0] gi; logic [RW-1:0] gd; logic ge; bit ok; exp_t e;
        load_job(0, 3, '{2, 0, 0, 0, 3, 0, 0, 0, 4});
        load_job(1, 2, '{1, 2, 3, 4, 0, 0, 0, 0, 0});
        load_job(2, 3, '{1, 2, 3, 4, 5, 6, 7, 8, 10});
        push_exp(0, 24, 1'b0);
        push_exp(1, -2, 1'b0);
        push_exp(2, -3, 1'b0);
        res_ready = 1'b1;
        start_batch(3);
        for (int r = 0; r < 3; r++) begin
            wait_hs(300, gi, gd, ge, ok);
            e = sb.pop_front();
            tests++;
            if (!ok || gi !== e.idx || gd !== e.data || ge !== e.err) begin
                fails++;
                $display("FAIL three_res%0d: ok=%b idx=%0d data=%0d err=%b want idx=%0d data=%0d err=%b",
                         r, ok, gi, $signed(gd), ge, e.idx, $signed(e.data), e.err);
            end
            if (r == 0) begin
                // A start pulse mid-batch must be ignored.
                start = 1'b1; num_jobs = JW'(1);
                @(negedge clk);
                start = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL three_done: done=%b want 1", done);
        end
    endtask

    task automatic test_bad_n();
        logic [JW-1:0] gi; logic [RW-1:0] gd; logic ge; bit ok; exp_t e;
        load_job(0, 2, '{3, 1, 2, 4, 0, 0, 0, 0, 0});
        mem[16] = MAX'(5);
        push_exp(0, 10, 1'b0);
        push_exp(1, 0, 1'b1);
        res_ready = 1'b1;
        start_batch(2);
        for (int r = 0; r < 2; r++) begin
            wait_hs(300, gi, gd, ge, ok);
            e = sb.pop_front();
            tests++;
            if (!ok || gi !== e.idx || gd !== e.data || ge !== e.err) begin
                fails++;
                $display("FAIL badn_res%0d: ok=%b idx=%0d data=%0d err=%b want idx=%0d data=%0d err=%b",
                         r, ok, gi, $signed(gd), ge, e.idx, $signed(e.data), e.err);
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL badn_done: done=%b want 1", done);
        end
    endtask

    task automatic test_backpressure();
        int cyc; exp_t e; logic [JW+3:0] a0;
        load_job(0, 2, '{5, 2, 1, 3, 0, 0, 0, 0, 0});
        push_exp(0, 13, 1'b0);
        res_ready = 1'b0;
        start_batch(1);
        cyc = 0;
        while (!res_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        tests++;
        if (res_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_valid: res_valid=%b want 1 within 200 cycles", res_valid);
        end
        a0 = mem_addr;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (res_valid !== 1'b1 || res_data !== e.data || res_err !== e.err
                || eng_reset !== 1'b1 || mem_addr !== a0) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d err=%b eng_reset=%b addr=%0d want 1 %0d %b 1 %0d",
                         c, res_valid, $signed(res_data), res_err, eng_reset, mem_addr,
                         $signed(e.data), e.err, a0);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_done: done=%b valid=%b want 1 0", done, res_valid);
        end
    endtask

    task automatic test_timeout();
        logic [JW-1:0] gi; logic [RW-1:0] gd; logic ge; bit ok; exp_t e; int cyc;
        load_job(0, 2, '{3, 1, 2, 4, 0, 0, 0, 0, 0});
        load_job(1, 2, '{1, 2, 3, 4, 0, 0, 0, 0, 0});
        hang_mask = 16'h0001;
        push_exp(0, 0, 1'b1);
        push_exp(1, -2, 1'b0);
        res_ready = 1'b1;
        start_batch(2);
        cyc = 0;
        while (!res_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        // HOLD + HDR + TIMEOUT RUN cycles before EMIT.
        tests++;
        if (cyc != 2 + TO) begin
            fails++;
            $display("FAIL to_latency: cycles=%0d want %0d", cyc, 2 + TO);
        end
        e = sb.pop_front();
        tests++;
        if (res_idx !== e.idx || res_data !== e.data || res_err !== e.err) begin
            fails++;
            $display("FAIL to_res: idx=%0d data=%0d err=%b want idx=%0d data=%0d err=%b",
                     res_idx, $signed(res_data), res_err, e.idx, $signed(e.data), e.err);
        end
        wait_hs(300, gi, gd, ge, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || gi !== e.idx || gd !== e.data || ge !== e.err) begin
            fails++;
            $display("FAIL to_next: ok=%b idx=%0d data=%0d err=%b want idx=%0d data=%0d err=%b",
                     ok, gi, $signed(gd), ge, e.idx, $signed(e.data), e.err);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL to_done: done=%b want 1", done);
        end
        hang_mask = '0;
    endtask

    task automatic test_zero_jobs();
        start_batch(0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done=%b busy=%b valid=%b want 1 1 0", done, busy, res_valid);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [JW-1:0] gi; logic [RW-1:0] gd; logic ge; bit ok; exp_t e; bit saw_done;
        load_job(0, 2, '{3, 1, 2, 4, 0, 0, 0, 0, 0});
        load_job(1, 2, '{1, 2, 3, 4, 0, 0, 0, 0, 0});
        push_exp(0, 10, 1'b0);
        res_ready = 1'b1;
        start_batch(2);
        wait_hs(200, gi, gd, ge, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || gi !== e.idx || gd !== e.data || ge !== e.err) begin
            fails++;
            $display("FAIL rst_job0: ok=%b idx=%0d data=%0d err=%b want idx=%0d data=%0d err=%b",
                     ok, gi, $signed(gd), ge, e.idx, $signed(e.data), e.err);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (eng_reset !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_inrun: eng_reset=%b busy=%b want 0 1", eng_reset, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || eng_reset !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_idle: busy=%b valid=%b eng_reset=%b done=%b want 0 0 1 0",
                     busy, res_valid, eng_reset, done);
        end
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || res_valid === 1'b1) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL rst_quiet: saw done/valid=1 want 0 after reset");
        end
        push_exp(0, 10, 1'b0);
        start_batch(1);
        wait_hs(200, gi, gd, ge, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || gi !== e.idx || gd !== e.data || ge !== e.err) begin
            fails++;
            $display("FAIL rst_rerun: ok=%b idx=%0d data=%0d err=%b want idx=%0d data=%0d err=%b",
                     ok, gi, $signed(gd), ge, e.idx, $signed(e.data), e.err);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL rst_done: done=%b want 1", done);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        eng_write_data = '0;
        eng_finish     = 1'b0;
        eng_i          = '0;
        eng_j          = '0;
        test_reset();
        test_single();
        test_three_jobs();
        test_bad_n();
        test_backpressure();
        test_timeout();
        test_zero_jobs();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
